vector_writeback_serializer: RTL and testbench
==============================================

VECTOR_WRITEBACK_SERIALIZER -- requirements
Module: vector_writeback_serializer

Interface
REQ-001 The block SHALL have parameter N, default 32, giving element width in bits.
REQ-002 The block SHALL have parameter V, default 20, giving the number of result vector lanes.
REQ-003 The block SHALL have parameter L, default 4, giving the lanes written per beat; V SHALL be an integer multiple of L, so the default is 5 beats.
REQ-004 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-005 The block SHALL have the following ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous active-high reset.
- in_valid_i  input  1  execute result is present on vec_i and rd_i.
- in_ready_o  output  1  block can accept a result this cycle.
- vec_i  input  V x N  joined result vector from the execute stage.
- rd_i  input  5  destination vector register index.
- wb_ready_i  input  1  register file accepts the presented beat this cycle.
- we_o  output  1  a write beat is presented.
- waddr_o  output  5  destination register of the beat.
- wbeat_o  output  3  beat index 0..V/L-1; lanes written are wbeat_o*L .. wbeat_o*L+L-1.
- wdata_o  output  L x N  lane data of the beat; wdata_o[j] = captured vec[wbeat_o*L+j].
- busy_o  output  1  a transfer is in progress.
- done_o  output  1  one-cycle pulse after the final beat is accepted.

Function
REQ-006 The FSM SHALL have the states IDLE and WRITE; done_o SHALL be a registered flag, not a state.
REQ-007 In IDLE, in_ready_o SHALL be 1 and we_o SHALL be 0.
REQ-008 In WRITE, in_ready_o SHALL be 0 and we_o SHALL be 1.
REQ-009 An input handshake SHALL occur when in_valid_i=1 and in_ready_o=1 at a rising edge.
REQ-010 On an input handshake, the block SHALL capture vec_i and rd_i, clear the beat counter to 0, and enter WRITE.
REQ-011 Captured data SHALL be immune to later changes on vec_i and rd_i.
REQ-012 The first beat SHALL be presented in the cycle after the input handshake, giving a latency of 1 cycle.
REQ-013 A beat SHALL be accepted when we_o=1 and wb_ready_i=1 at a rising edge.
REQ-014 On beat acceptance, the beat counter SHALL increment by 1.
REQ-015 While wb_ready_i=0 the block SHALL stall: we_o, waddr_o, wbeat_o and wdata_o SHALL be held unchanged.
REQ-016 When beat V/L-1 is accepted, the FSM SHALL return to IDLE; the counter SHALL NOT wrap to 0 within WRITE.
REQ-017 On the edge where beat V/L-1 is accepted, done_o SHALL be set to 1 for exactly the following cycle.
REQ-018 In the cycle where done_o=1, in_ready_o SHALL also be 1, so a new result may be accepted and back-to-back transfers lose only that one cycle.
REQ-019 With wb_ready_i held at 1, a transfer SHALL take exactly V/L cycles of we_o=1, each beat index appearing once, in ascending order.
REQ-020 busy_o SHALL equal (state == WRITE).
REQ-021 in_valid_i SHALL be ignored while in WRITE; no result is dropped, because the upstream stage holds its data until in_ready_o=1.
REQ-022 Outside WRITE, waddr_o, wbeat_o and wdata_o SHALL be 0.

Reset
REQ-023 While RST=1 at a rising edge, the block SHALL enter IDLE, clear the beat counter, captured register index and captured vector to 0, and clear done_o to 0.
REQ-024 The reset values of the outputs SHALL be: in_ready_o=1, we_o=0, busy_o=0, done_o=0, waddr_o=0, wbeat_o=0, wdata_o=0.
REQ-025 A reset during WRITE SHALL abort the transfer with no further beats and no done_o pulse.
REQ-026 RST SHALL take priority over a simultaneous input handshake or beat acceptance.

Verification
REQ-027 The bench SHALL cover the following directed scenarios:
- Basic: vec_i[i]=i, rd_i=7, wb_ready_i=1, one handshake -> 5 consecutive beats 0..4, waddr_o=7; beat 2 has wdata_o={8,9,10,11}; done_o pulses 1 cycle after beat 4.
- Stall: wb_ready_i=0 during beat 1 for 3 cycles -> beat 1 held unchanged for 4 cycles total; total we_o-high cycles=8; data still correct.
- Back-to-back: second result (vec_i[i]=2i, rd_i=3) held valid during the first transfer -> accepted in the done_o cycle; beats restart at 0 with waddr_o=3; exactly one idle cycle between the two transfers.
- Input change: vec_i and rd_i altered every cycle after the handshake -> all 5 beats carry the captured values.
- Reset mid-transfer: RST=1 for one cycle during beat 2 -> next cycle we_o=0, in_ready_o=1, no done_o; a subsequent transfer completes correctly.
- Reset during a valid handshake: RST=1 and in_valid_i=1 on the same edge -> block remains IDLE with no beats.

Source files
------------

// File: rtl/vector_writeback_serializer.sv
// Splits one wide execute result into V/L register-file write beats of L lanes each.
// A new result is accepted only from IDLE, which includes the cycle that carries the done pulse.
module vector_writeback_serializer #(
  parameter int N = 32,
  parameter int V = 20,
  parameter int L = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [V-1:0][N-1:0]   vec_i,
  input  logic [4:0]            rd_i,
  input  logic                  wb_ready_i,
  output logic                  we_o,
  output logic [4:0]            waddr_o,
  output logic [2:0]            wbeat_o,
  output logic [L-1:0][N-1:0]   wdata_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int BEATS = V / L;
  localparam logic [2:0] LAST = 3'(BEATS - 1);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t             state, next_state;
  logic [2:0]         beat;
  logic [4:0]         rd_q;
  logic [V-1:0][N-1:0] vec_q;
  logic               done_q;
  logic [L-1:0][N-1:0] beat_data [8];

  // Pre-slice the captured vector per beat so the output mux uses the 3-bit beat index directly.
  for (genvar b = 0; b < 8; b++) begin : g_beat
    if (b < BEATS) begin : g_used
      assign beat_data[b] = vec_q[b*L +: L];
    end else begin : g_unused
      assign beat_data[b] = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (in_valid_i) next_state = WRITE;
      WRITE: if (wb_ready_i && beat == LAST) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The counter parks on the last beat when leaving WRITE; it is cleared again at the next capture.
  always_ff @(posedge CLK) begin
    if (RST) begin
      beat   <= '0;
      rd_q   <= '0;
      vec_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid_i) begin
            vec_q <= vec_i;
            rd_q  <= rd_i;
            beat  <= '0;
          end
        end
        WRITE: begin
          if (wb_ready_i) begin
            if (beat == LAST) begin
              done_q <= 1'b1;
            end else begin
              beat <= beat + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready_o = (state == IDLE);
    we_o       = (state == WRITE);
    busy_o     = (state == WRITE);
    done_o     = done_q;
    waddr_o    = '0;
    wbeat_o    = '0;
    wdata_o    = '0;
    if (state == WRITE) begin
      waddr_o = rd_q;
      wbeat_o = beat;
      wdata_o = beat_data[beat];
    end
  end

endmodule

// File: tb/tb_vector_writeback_serializer.sv
// Directed self-checking bench for vector_writeback_serializer at default parameters (5 beats of 4 lanes).
module tb_vector_writeback_serializer;

  localparam int N = 32;
  localparam int V = 20;
  localparam int L = 4;
  localparam int BEATS = V / L;

  logic                CLK;
  logic                RST;
  logic                in_valid_i;
  logic                in_ready_o;
  logic [V-1:0][N-1:0] vec_i;
  logic [4:0]          rd_i;
  logic                wb_ready_i;
  logic                we_o;
  logic [4:0]          waddr_o;
  logic [2:0]          wbeat_o;
  logic [L-1:0][N-1:0] wdata_o;
  logic                busy_o;
  logic                done_o;

  int testCount = 0;
  int failCount = 0;

  vector_writeback_serializer #(.N(N), .V(V), .L(L)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .vec_i      (vec_i),
    .rd_i       (rd_i),
    .wb_ready_i (wb_ready_i),
    .we_o       (we_o),
    .waddr_o    (waddr_o),
    .wbeat_o    (wbeat_o),
    .wdata_o    (wdata_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic setVec(input int mult);
    for (int i = 0; i < V; i++) vec_i[i] = 32'(mult * i);
  endtask

  function automatic logic [127:0] expData(input int mult, input int b);
    logic [L-1:0][N-1:0] d;
    for (int j = 0; j < L; j++) d[j] = 32'(mult * (b * L + j));
    return 128'(d);
  endfunction

  task automatic applyStimulus(input int mult, input logic [4:0] rd);
    setVec(mult);
    rd_i = rd;
    in_valid_i = 1'b1;
    cycle();
  endtask

  // Walks all beats starting in the cycle where beat 0 is presented; ends in the cycle after the last accept.
  task automatic runBeats(input string name, input int mult, input logic [4:0] rdExp,
                          input int stallBeat, input int stallLen, input bit scramble,
                          output int weCount);
    weCount = 0;
    for (int b = 0; b < BEATS; b++) begin
      int hold;
      hold = (b == stallBeat) ? stallLen : 0;
      for (int s = 0; s <= hold; s++) begin
        wb_ready_i = (s < hold) ? 1'b0 : 1'b1;
        checkOutput($sformatf("%s_b%0d_s%0d_we", name, b, s), 128'(we_o), 128'(1'b1));
        checkOutput($sformatf("%s_b%0d_s%0d_beat", name, b, s), 128'(wbeat_o), 128'(b));
        checkOutput($sformatf("%s_b%0d_s%0d_addr", name, b, s), 128'(waddr_o), 128'(rdExp));
        checkOutput($sformatf("%s_b%0d_s%0d_data", name, b, s), 128'(wdata_o), expData(mult, b));
        checkOutput($sformatf("%s_b%0d_s%0d_done", name, b, s), 128'(done_o), 128'(1'b0));
        checkOutput($sformatf("%s_b%0d_s%0d_rdy", name, b, s), 128'(in_ready_o), 128'(1'b0));
        if (we_o) weCount++;
        if (scramble) begin
          for (int i = 0; i < V; i++) vec_i[i] = $urandom;
          rd_i = 5'($urandom);
        end
        cycle();
      end
    end
    checkOutput({name, "_done_pulse"}, 128'(done_o), 128'(1'b1));
    checkOutput({name, "_done_we"}, 128'(we_o), 128'(1'b0));
    checkOutput({name, "_done_rdy"}, 128'(in_ready_o), 128'(1'b1));
    checkOutput({name, "_done_addr"}, 128'(waddr_o), 128'(0));
    checkOutput({name, "_done_data"}, 128'(wdata_o), 128'(0));
  endtask

  initial begin
    int weCount;
    RST = 1'b1;
    in_valid_i = 1'b0;
    wb_ready_i = 1'b1;
    rd_i = '0;
    setVec(0);
    cycle();
    cycle();
    checkOutput("rst_ready", 128'(in_ready_o), 128'(1'b1));
    checkOutput("rst_we", 128'(we_o), 128'(1'b0));
    checkOutput("rst_busy", 128'(busy_o), 128'(1'b0));
    checkOutput("rst_done", 128'(done_o), 128'(1'b0));
    checkOutput("rst_addr", 128'(waddr_o), 128'(0));
    checkOutput("rst_beat", 128'(wbeat_o), 128'(0));
    checkOutput("rst_data", 128'(wdata_o), 128'(0));
    RST = 1'b0;
    cycle();

    // Basic transfer.
    applyStimulus(1, 5'd7);
    in_valid_i = 1'b0;
    checkOutput("basic_busy", 128'(busy_o), 128'(1'b1));
    checkOutput("basic_b2_literal", expData(1, 2), {32'd11, 32'd10, 32'd9, 32'd8});
    runBeats("basic", 1, 5'd7, -1, 0, 1'b0, weCount);
    checkOutput("basic_we_count", 128'(weCount), 128'(5));
    cycle();
    checkOutput("basic_done_once", 128'(done_o), 128'(1'b0));
    checkOutput("basic_idle_busy", 128'(busy_o), 128'(1'b0));

    // Stall on beat 1 for three cycles.
    applyStimulus(1, 5'd12);
    in_valid_i = 1'b0;
    runBeats("stall", 1, 5'd12, 1, 3, 1'b0, weCount);
    checkOutput("stall_we_count", 128'(weCount), 128'(8));
    cycle();

    // Back-to-back: second result held valid throughout the first transfer.
    applyStimulus(1, 5'd7);
    setVec(2);
    rd_i = 5'd3;
    runBeats("b2b_first", 1, 5'd7, -1, 0, 1'b0, weCount);
    cycle();
    in_valid_i = 1'b0;
    runBeats("b2b_second", 2, 5'd3, -1, 0, 1'b0, weCount);
    cycle();

    // Inputs scrambled every cycle after capture.
    applyStimulus(3, 5'd21);
    in_valid_i = 1'b0;
    runBeats("scramble", 3, 5'd21, -1, 0, 1'b1, weCount);
    cycle();

    // Reset while beat 2 is presented.
    applyStimulus(1, 5'd5);
    in_valid_i = 1'b0;
    cycle();
    cycle();
    checkOutput("midrst_pre_beat", 128'(wbeat_o), 128'(2));
    RST = 1'b1;
    cycle();
    RST = 1'b0;
    checkOutput("midrst_we", 128'(we_o), 128'(1'b0));
    checkOutput("midrst_ready", 128'(in_ready_o), 128'(1'b1));
    checkOutput("midrst_done", 128'(done_o), 128'(1'b0));
    checkOutput("midrst_beat", 128'(wbeat_o), 128'(0));
    cycle();
    checkOutput("midrst_done_later", 128'(done_o), 128'(1'b0));
    checkOutput("midrst_we_later", 128'(we_o), 128'(1'b0));
    applyStimulus(2, 5'd9);
    in_valid_i = 1'b0;
    runBeats("after_rst", 2, 5'd9, -1, 0, 1'b0, weCount);
    cycle();

    // Reset coincident with a valid handshake.
    setVec(4);
    rd_i = 5'd30;
    in_valid_i = 1'b1;
    RST = 1'b1;
    cycle();
    RST = 1'b0;
    in_valid_i = 1'b0;
    checkOutput("rsths_busy", 128'(busy_o), 128'(1'b0));
    checkOutput("rsths_we", 128'(we_o), 128'(1'b0));
    cycle();
    checkOutput("rsths_we_later", 128'(we_o), 128'(1'b0));
    checkOutput("rsths_ready", 128'(in_ready_o), 128'(1'b1));

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
